// File: rtl/score_display_mux.sv
// score_display_mux: time-multiplexed three-digit seven-segment driver.
// Scans ones -> tens -> hundreds, SCAN_DIV cycles per digit. The BCD inputs
// are snapshotted once per scan frame so a digit can never tear mid-frame.
// Codes 10..15 are shown as a dash. While isGameComplete is high the whole
// display blinks with a half-period of BLINK_FRAMES frames.
// Optional feature macro: SCORE_DISP_LZB_EN enables leading-zero blanking
// of the hundreds and tens digits. Without it all three digits are driven.
module score_display_mux #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] bcd_ones,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_hundreds,
  input  logic       isGameComplete,
  output logic [6:0] seg,
  output logic [2:0] digit_en,
  output logic       frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    IDX_LAST  = 2'd2;

  // Seven-segment pattern {g,f,e,d,c,b,a}; anything that is not BCD shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  // Current state
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          run;
  logic [3:0]    snap_o, snap_t, snap_h;
  logic [BW-1:0] bcnt;
  logic          bph;

  // Next-state and next-output values (stage p0)
  logic          frame_go;
  logic          cnt_wrap;
  logic [CW-1:0] cnt_p0;
  logic [1:0]    idx_p0;
  logic [3:0]    snap_o_p0, snap_t_p0, snap_h_p0;
  logic [BW-1:0] bcnt_p0;
  logic          bph_p0;
  logic [3:0]    code_p0;
  logic [2:0]    onehot_p0;
  logic          blank_p0;
  logic [6:0]    seg_p0;
  logic [2:0]    digit_en_p0;

  // Registered outputs (stage p1)
  logic [6:0]    seg_p1;
  logic [2:0]    digit_en_p1;
  logic          frame_start_p1;

  // Scan position: the first edge after reset is itself a frame start at slot 0.
  always_comb begin
    cnt_wrap = (cnt == CNT_LAST);
    frame_go = !run || (cnt_wrap && (idx == IDX_LAST));
    cnt_p0   = cnt;
    idx_p0   = idx;
    if (!run) begin
      cnt_p0 = '0;
      idx_p0 = 2'd0;
    end else if (cnt_wrap) begin
      cnt_p0 = '0;
      idx_p0 = (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt_p0 = cnt + 1'b1;
    end
  end

  // Snapshot of the score, refreshed only at frame start.
  always_comb begin
    snap_o_p0 = snap_o;
    snap_t_p0 = snap_t;
    snap_h_p0 = snap_h;
    if (frame_go) begin
      snap_o_p0 = bcd_ones;
      snap_t_p0 = bcd_tens;
      snap_h_p0 = bcd_hundreds;
    end
  end

  // Blink phase: counts frames while the game is complete; dropping the flag
  // returns to the visible phase on the very next edge.
  always_comb begin
    bcnt_p0 = bcnt;
    bph_p0  = bph;
    if (!isGameComplete) begin
      bcnt_p0 = '0;
      bph_p0  = 1'b1;
    end else if (frame_go) begin
      if (bcnt == BCNT_LAST) begin
        bcnt_p0 = '0;
        bph_p0  = ~bph;
      end else begin
        bcnt_p0 = bcnt + 1'b1;
      end
    end
  end

  // Slot selection, blanking and decode for the slot that becomes active.
  always_comb begin
    code_p0   = snap_o_p0;
    onehot_p0 = 3'b001;
    blank_p0  = 1'b0;
    case (idx_p0)
      2'd1: begin
        code_p0   = snap_t_p0;
        onehot_p0 = 3'b010;
`ifdef SCORE_DISP_LZB_EN
        blank_p0  = (snap_h_p0 == 4'd0) && (snap_t_p0 == 4'd0);
`endif
      end
      2'd2: begin
        code_p0   = snap_h_p0;
        onehot_p0 = 3'b100;
`ifdef SCORE_DISP_LZB_EN
        blank_p0  = (snap_h_p0 == 4'd0);
`endif
      end
      default: begin
        code_p0   = snap_o_p0;
        onehot_p0 = 3'b001;
      end
    endcase
    if (bph_p0 && !blank_p0) begin
      seg_p0      = seg_decode(code_p0);
      digit_en_p0 = onehot_p0;
    end else begin
      seg_p0      = 7'h00;
      digit_en_p0 = 3'b000;
    end
  end

  // State registers; the async reset restarts the scan from a frame start.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt    <= '0;
      idx    <= 2'd0;
      run    <= 1'b0;
      snap_o <= 4'd0;
      snap_t <= 4'd0;
      snap_h <= 4'd0;
      bcnt   <= '0;
      bph    <= 1'b1;
    end else begin
      cnt    <= cnt_p0;
      idx    <= idx_p0;
      run    <= 1'b1;
      snap_o <= snap_o_p0;
      snap_t <= snap_t_p0;
      snap_h <= snap_h_p0;
      bcnt   <= bcnt_p0;
      bph    <= bph_p0;
    end
  end

  // ---- p0 -> p1: output registers, glitch-free toward the display pins ----
  // Output registers cleared immediately by reset.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      seg_p1         <= 7'h00;
      digit_en_p1    <= 3'b000;
      frame_start_p1 <= 1'b0;
    end else begin
      seg_p1         <= seg_p0;
      digit_en_p1    <= digit_en_p0;
      frame_start_p1 <= frame_go;
    end
  end

  assign seg         = seg_p1;
  assign digit_en    = digit_en_p1;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_score_display_mux.sv
// Testbench for score_display_mux with SCAN_DIV=4, BLINK_FRAMES=2.
// A cycle-indexed reference model derives the expected outputs from the
// elapsed cycle count since reset release.
module tb_score_display_mux;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FL = 3 * SD;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [3:0] bcd_ones = 4'd3;
  logic [3:0] bcd_tens = 4'd2;
  logic [3:0] bcd_hundreds = 4'd1;
  logic       isGameComplete = 1'b0;
  logic [6:0] seg;
  logic [2:0] digit_en;
  logic       frame_start;

  score_display_mux #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk),
    .nRst(nRst),
    .bcd_ones(bcd_ones),
    .bcd_tens(bcd_tens),
    .bcd_hundreds(bcd_hundreds),
    .isGameComplete(isGameComplete),
    .seg(seg),
    .digit_en(digit_en),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         k = -1;      // edges since reset release (0 = first edge)
  int         gcf = 0;     // frame starts seen while game complete held high
  logic [3:0] m_snap [3];  // 0 ones, 1 tens, 2 hundreds
  logic [6:0] exp_seg;
  logic [2:0] exp_en;
  logic       exp_fs;
  logic [6:0] dec_tab [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int ph;
    int slot;
    logic vis;
    logic blank;
    k++;
    ph = k % FL;
    exp_fs = (ph == 0);
    if (ph == 0) begin
      m_snap[0] = bcd_ones;
      m_snap[1] = bcd_tens;
      m_snap[2] = bcd_hundreds;
    end
    if (!isGameComplete) gcf = 0;
    else if (ph == 0) gcf++;
    vis = (((gcf / BF) % 2) == 0);
    slot = ph / SD;
    blank = 1'b0;
`ifdef SCORE_DISP_LZB_EN
    if (slot == 2 && m_snap[2] == 4'd0) blank = 1'b1;
    if (slot == 1 && m_snap[2] == 4'd0 && m_snap[1] == 4'd0) blank = 1'b1;
`endif
    if (vis && !blank) begin
      exp_en  = 3'(1 << slot);
      exp_seg = dec_tab[m_snap[slot]];
    end else begin
      exp_en  = 3'b000;
      exp_seg = 7'h00;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    check({tag, "_en"}, 32'(digit_en), 32'(exp_en));
    check({tag, "_fs"}, 32'(frame_start), 32'(exp_fs));
    check({tag, "_onehot"}, 32'($countones(digit_en) <= 1), 32'd1);
  endtask

  task automatic run_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'd0);
    check({tag, "_en"}, 32'(digit_en), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    m_snap[0] = 4'd0;
    m_snap[1] = 4'd0;
    m_snap[2] = 4'd0;

    // Reset held: all outputs low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");

    // Score 123
    nRst = 1'b1;
    run_cycles("s123", 2 * FL);

    // Score 007: leading zeros blanked when the feature is built in
    bcd_hundreds = 4'd0; bcd_tens = 4'd0; bcd_ones = 4'd7;
    run_cycles("s007", 2 * FL + 3);

    // Ones 5 -> 6 at cycle 2 of a frame: no change until the next frame
    bcd_hundreds = 4'd4; bcd_tens = 4'd0; bcd_ones = 4'd5;
    while (k % FL != 2) step("s405");
    bcd_ones = 4'd6;
    run_cycles("s406", 2 * FL);

    // Dash in tens keeps that slot on; hundreds zero still blanked
    bcd_hundreds = 4'd0; bcd_tens = 4'hC; bcd_ones = 4'd1;
    run_cycles("dash", 2 * FL);

    // Blink for several half-periods, then drop mid-frame
    bcd_hundreds = 4'd9; bcd_tens = 4'd8; bcd_ones = 4'd0;
    isGameComplete = 1'b1;
    run_cycles("blink", 9 * FL + 5);
    isGameComplete = 1'b0;
    run_cycles("unblink", FL);

    // Reset pulse mid-slot
    run_cycles("pre_rst", 6);
    #2 nRst = 1'b0;
    #1 check_zero("mid_rst");
    @(posedge clk);
    @(negedge clk);
    check_zero("mid_rst_hold");
    nRst = 1'b1;
    k = -1;
    gcf = 0;
    run_cycles("post_rst", 2 * FL);

    // Randomized traffic
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: bcd_ones     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          1: bcd_tens     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          default: bcd_hundreds = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 99) == 0) isGameComplete = ~isGameComplete;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
